// File: rtl/ssd_display_ctrl_pkg.sv
// Shared constants for the seven-segment display controller.
// Segment codes are {a,b,c,d,e,f,g}, active-low; anode patterns are one-cold, active-low.
package ssd_display_ctrl_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] an_t;

    // Indexed by hex value: SEG7[4'hA] is the code for 'A'.
    localparam logic [15:0][6:0] SEG7 = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    localparam an_t AN_D0 = 4'b1110;
    localparam an_t AN_D1 = 4'b1101;
    localparam an_t AN_D2 = 4'b1011;
    localparam an_t AN_D3 = 4'b0111;

endpackage

// File: rtl/ssd_hex_decoder.sv
// Hex nibble to active-low seven-segment code.
// Latency: combinational. Backpressure: none.
module ssd_hex_decoder
    import ssd_display_ctrl_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG7[i_nibble];

endmodule

// File: rtl/ssd_display_ctrl.sv
// Four-digit common-anode display scanner with scan/slow tick dividers.
// Latency: ticks registered, seg combinational from sel/disp. Backpressure: none.
module ssd_display_ctrl
    import ssd_display_ctrl_pkg::*;
#(
    parameter int SCAN_DIV = 200000,
    parameter int SLOW_DIV = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [15:0] disp_a,
    input  logic [15:0] disp_b,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        scan_tick,
    output logic        slow_tick
);

    localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int SLOW_W = (SLOW_DIV > 2) ? $clog2(SLOW_DIV) : 1;

    logic [SCAN_W-1:0] r_scan_cnt;
    logic [SLOW_W-1:0] r_slow_cnt;
    logic              r_scan_tick;
    logic              r_slow_tick;
    an_t               r_an;

    logic              w_scan_wrap;
    logic              w_slow_wrap;
    an_t               w_an_next;
    logic [15:0]       w_val;
    logic [3:0]        w_nibble;

    assign w_scan_wrap = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign w_slow_wrap = (r_slow_cnt == SLOW_W'(SLOW_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan_cnt  <= '0;
            r_scan_tick <= 1'b0;
        end else begin
            r_scan_cnt  <= w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
            r_scan_tick <= w_scan_wrap;
        end
    end

    // Slow divider counts on the same edge that issues scan_tick, so both
    // pulses land together and the slow period is exactly SCAN_DIV*SLOW_DIV.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slow_cnt  <= '0;
            r_slow_tick <= 1'b0;
        end else begin
            r_slow_tick <= 1'b0;
            if (w_scan_wrap) begin
                r_slow_cnt  <= w_slow_wrap ? '0 : r_slow_cnt + 1'b1;
                r_slow_tick <= w_slow_wrap;
            end
        end
    end

    always_comb begin
        w_an_next = AN_D0;
        case (r_an)
            AN_D0:   w_an_next = AN_D1;
            AN_D1:   w_an_next = AN_D2;
            AN_D2:   w_an_next = AN_D3;
            AN_D3:   w_an_next = AN_D0;
            default: w_an_next = AN_D0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an <= AN_D0;
        end else if (r_scan_tick) begin
            r_an <= w_an_next;
        end
    end

    assign w_val = sel ? disp_a : disp_b;

    always_comb begin
        w_nibble = w_val[15:12];
        case (r_an)
            AN_D0:   w_nibble = w_val[3:0];
            AN_D1:   w_nibble = w_val[7:4];
            AN_D2:   w_nibble = w_val[11:8];
            AN_D3:   w_nibble = w_val[15:12];
            default: w_nibble = w_val[15:12];
        endcase
    end

    ssd_hex_decoder u_dec (
        .i_nibble (w_nibble),
        .o_seg    (seg)
    );

    assign an        = r_an;
    assign scan_tick = r_scan_tick;
    assign slow_tick = r_slow_tick;

endmodule

// File: tb/tb_ssd_display_ctrl.sv
// Directed bench for ssd_display_ctrl with SCAN_DIV=4, SLOW_DIV=3.
module tb_ssd_display_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [15:0] disp_a;
    logic [15:0] disp_b;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        scan_tick;
    logic        slow_tick;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ssd_display_ctrl #(
        .SCAN_DIV (4),
        .SLOW_DIV (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sel       (sel),
        .disp_a    (disp_a),
        .disp_b    (disp_b),
        .an        (an),
        .seg       (seg),
        .scan_tick (scan_tick),
        .slow_tick (slow_tick)
    );

    typedef struct {
        logic        sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [6:0]  exp_seg;
    } vec_t;

    vec_t       vecs [20];
    logic [6:0] seg_ref [16];
    logic [3:0] an_ref [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Edge e counts rising edges since reset release; samples 1 time unit after the edge.
    task automatic run_edges(input int n, input string tag);
        int         idx;
        logic [3:0] nib;
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            #1;
            idx = ((e - 1) / 4) % 4;
            check($sformatf("%s an e%0d", tag, e), {28'h0, an}, {28'h0, an_ref[idx]});
            check($sformatf("%s scan_tick e%0d", tag, e), {31'h0, scan_tick}, {31'h0, (e % 4 == 0)});
            check($sformatf("%s slow_tick e%0d", tag, e), {31'h0, slow_tick}, {31'h0, (e % 12 == 0)});
            nib = 4'(disp_a >> (4 * idx));
            check($sformatf("%s seg sel1 e%0d", tag, e), {25'h0, seg}, {25'h0, seg_ref[nib]});
            sel = 1'b0;
            #1;
            nib = 4'(disp_b >> (4 * idx));
            check($sformatf("%s seg sel0 e%0d", tag, e), {25'h0, seg}, {25'h0, seg_ref[nib]});
            sel = 1'b1;
        end
    endtask

    initial begin
        seg_ref = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        an_ref  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        for (int i = 0; i < 16; i++) begin
            vecs[i].sel     = 1'b1;
            vecs[i].a       = {12'h000, i[3:0]};
            vecs[i].b       = {12'hFFF, ~i[3:0]};
            vecs[i].exp_seg = seg_ref[i];
        end
        vecs[16] = '{1'b1, 16'h1234, 16'hABCD, 7'b1001100};
        vecs[17] = '{1'b0, 16'h1234, 16'hABCD, 7'b1000010};
        vecs[18] = '{1'b0, 16'h0000, 16'h000F, 7'b0111000};
        vecs[19] = '{1'b1, 16'hFFF0, 16'h1111, 7'b0000001};

        reset  = 1'b0;
        sel    = 1'b1;
        disp_a = 16'h0000;
        disp_b = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset an", {28'h0, an}, 32'he);
        check("reset scan_tick", {31'h0, scan_tick}, 32'h0);
        check("reset slow_tick", {31'h0, slow_tick}, 32'h0);

        // an stays 1110 while reset is held, so digit 0 is on display.
        for (int i = 0; i < 20; i++) begin
            sel    = vecs[i].sel;
            disp_a = vecs[i].a;
            disp_b = vecs[i].b;
            #1;
            check($sformatf("decode vec%0d", i), {25'h0, seg}, {25'h0, vecs[i].exp_seg});
        end

        sel    = 1'b1;
        disp_a = 16'h1234;
        disp_b = 16'hABCD;
        @(negedge clk);
        reset = 1'b1;
        run_edges(28, "run1");

        // After edge 28: an=1011 and scan_tick high; reset between edges.
        #1;
        reset = 1'b0;
        #1;
        check("async an", {28'h0, an}, 32'he);
        check("async scan_tick", {31'h0, scan_tick}, 32'h0);
        check("async slow_tick", {31'h0, slow_tick}, 32'h0);
        check("async seg", {25'h0, seg}, {25'h0, seg_ref[4]});

        @(negedge clk);
        reset = 1'b1;
        run_edges(13, "run2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
